// File: rtl/sgn_restore_pkg.sv
// sgn_restore_pkg: shared FSM state encodings for the sign-restore stage.
package sgn_restore_pkg;
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_PEND = 1'b1;
    typedef enum logic {IDLE = ST_IDLE, PEND = ST_PEND} sgn_state_t;
endpackage

// File: rtl/sgn_switch_fsm.sv
// sgn_switch_fsm: defers sign changes to a zero-crossing, with a hold timeout.
//   valid_i  : stage-1 sample strobe        sgn_i   : requested sign
//   zc_i     : sample is inside the crossing window (mag <= threshold)
//   hold_i   : samples to wait before forcing bypass_i: follow sgn_i directly
//   sgn_o    : sign applied to the current sample (combinational)
//   force_o  : current sample is a timeout-forced switch (combinational)
//   pend_o   : a sign change is waiting for a crossing
module sgn_switch_fsm
    import sgn_restore_pkg::*;
#(
    parameter int HOLD_W = 8
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              valid_i,
    input  logic              sgn_i,
    input  logic              zc_i,
    input  logic [HOLD_W-1:0] hold_i,
    input  logic              bypass_i,
    output logic              sgn_o,
    output logic              force_o,
    output logic              pend_o
);
    sgn_state_t        state_q, state_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic              app_q, app_d;
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            app_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            app_q   <= app_d;
        end
    end
    // A switch takes effect on the sample that triggers it, so the sign used
    // for the current sample is the next-state applied sign.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        app_d   = app_q;
        force_o = 1'b0;
        if (valid_i) begin
            if (bypass_i) begin
                state_d = IDLE;
                app_d   = sgn_i;
            end else if (sgn_i == app_q) begin
                state_d = IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (hold_i == '0 || zc_i) begin
                            app_d = sgn_i;
                        end else begin
                            cnt_d   = hold_i - 1'b1;
                            state_d = PEND;
                        end
                    end
                    PEND: begin
                        if (zc_i || cnt_q == '0) begin
                            state_d = IDLE;
                            app_d   = sgn_i;
                            force_o = !zc_i;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                endcase
            end
        end
    end
    assign sgn_o  = app_d;
    assign pend_o = state_q == PEND;
endmodule

// File: rtl/sgn_restore.sv
// sgn_restore: rebuilds a signed R-bit sample from an (R-1)-bit magnitude and sign.
//   mag_i/sgn_i/valid_i : input sample       zc_thr_i/hold_i : crossing window, timeout
//   bypass_i            : apply sgn_i on every sample
//   out_o/valid_o       : signed result, 2 cycles after valid_i
//   sgn_o               : applied sign       pend_o  : sign change waiting
//   force_o             : timeout switch     sat_o   : magnitude at full scale
module sgn_restore
    import sgn_restore_pkg::*;
#(
    parameter int R      = 14,
    parameter int HOLD_W = 8
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [R-2:0]      mag_i,
    input  logic              sgn_i,
    input  logic              valid_i,
    input  logic [R-2:0]      zc_thr_i,
    input  logic [HOLD_W-1:0] hold_i,
    input  logic              bypass_i,
    output logic [R-1:0]      out_o,
    output logic              valid_o,
    output logic              sgn_o,
    output logic              pend_o,
    output logic              force_o,
    output logic              sat_o
);
    logic [R-2:0]      s1_mag, s1_thr;
    logic [HOLD_W-1:0] s1_hold;
    logic              s1_sgn, s1_valid, s1_byp;
    logic              app, frc;
    logic [R-1:0]      mag_ext;
    // Control inputs travel with their sample so a gapped stream sees the
    // threshold and hold that accompanied it.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s1_mag   <= '0;
            s1_thr   <= '0;
            s1_hold  <= '0;
            s1_sgn   <= 1'b0;
            s1_valid <= 1'b0;
            s1_byp   <= 1'b0;
        end else begin
            s1_mag   <= mag_i;
            s1_thr   <= zc_thr_i;
            s1_hold  <= hold_i;
            s1_sgn   <= sgn_i;
            s1_valid <= valid_i;
            s1_byp   <= bypass_i;
        end
    end
    sgn_switch_fsm #(.HOLD_W(HOLD_W)) u_fsm (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .valid_i (s1_valid),
        .sgn_i   (s1_sgn),
        .zc_i    (s1_mag <= s1_thr),
        .hold_i  (s1_hold),
        .bypass_i(s1_byp),
        .sgn_o   (app),
        .force_o (frc),
        .pend_o  (pend_o)
    );
    // Zero-extended magnitude keeps the result symmetric: -2^(R-1) is unreachable.
    assign mag_ext = {1'b0, s1_mag};
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            out_o   <= '0;
            valid_o <= 1'b0;
            sgn_o   <= 1'b0;
            force_o <= 1'b0;
            sat_o   <= 1'b0;
        end else begin
            valid_o <= s1_valid;
            force_o <= frc;
            if (s1_valid) begin
                out_o <= app ? -mag_ext : mag_ext;
                sgn_o <= app;
                sat_o <= &s1_mag;
            end
        end
    end
endmodule

// File: tb/tb_sgn_restore.sv
// tb_sgn_restore: randomized scoreboard bench for sgn_restore.
module tb_sgn_restore;
    localparam int R = 14;
    localparam int HOLD_W = 8;
    localparam int FS = (1 << (R - 1)) - 1;

    logic              clk = 1'b0;
    logic              rstn_i = 1'b0;
    logic [R-2:0]      mag_i = '0;
    logic              sgn_i = 1'b0;
    logic              valid_i = 1'b0;
    logic [R-2:0]      zc_thr_i = '0;
    logic [HOLD_W-1:0] hold_i = '0;
    logic              bypass_i = 1'b0;
    logic [R-1:0]      out_o;
    logic              valid_o, sgn_o, pend_o, force_o, sat_o;

    sgn_restore #(.R(R), .HOLD_W(HOLD_W)) dut (
        .clk_i(clk), .rstn_i(rstn_i), .mag_i(mag_i), .sgn_i(sgn_i), .valid_i(valid_i),
        .zc_thr_i(zc_thr_i), .hold_i(hold_i), .bypass_i(bypass_i), .out_o(out_o),
        .valid_o(valid_o), .sgn_o(sgn_o), .pend_o(pend_o), .force_o(force_o), .sat_o(sat_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int out;
        int sgn;
        int pend;
        int frc;
        int sat;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   ncmp = 0;
    int   nerr = 0;

    // Reference model: applied sign, whether a request is waiting, how many
    // samples it has waited, and the hold it was granted at request time.
    int m_app = 0, m_pend = 0, m_wait = 0, m_hold = 0;
    int last_sgn = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_app = 0;
        m_pend = 0;
        m_wait = 0;
        m_hold = 0;
    endtask

    task automatic send(input int mag, input int sgn, input int thr, input int hold, input int byp);
        exp_t e;
        int   frc = 0;
        @(posedge clk);
        #1;
        mag_i = mag[R-2:0];
        sgn_i = sgn[0];
        zc_thr_i = thr[R-2:0];
        hold_i = hold[HOLD_W-1:0];
        bypass_i = byp[0];
        valid_i = 1'b1;
        last_sgn = sgn;
        if (byp != 0) begin
            m_app = sgn;
            m_pend = 0;
        end else if (m_pend == 0) begin
            if (sgn != m_app) begin
                if (hold == 0 || mag <= thr) m_app = sgn;
                else begin
                    m_pend = 1;
                    m_wait = 1;
                    m_hold = hold;
                end
            end
        end else if (sgn == m_app) begin
            m_pend = 0;
        end else if (mag <= thr) begin
            m_app = sgn;
            m_pend = 0;
        end else if (m_wait == m_hold) begin
            m_app = sgn;
            m_pend = 0;
            frc = 1;
        end else begin
            m_wait++;
        end
        e.out = m_app != 0 ? -mag : mag;
        e.sgn = m_app;
        e.pend = m_pend;
        e.frc = frc;
        e.sat = mag == FS ? 1 : 0;
        e.cyc = cyc + 2;
        q.push_back(e);
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            valid_i = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rstn_i = 1'b0;
        #1;
        chk("rst_out", int'(out_o), 0);
        chk("rst_valid", int'(valid_o), 0);
        chk("rst_sgn", int'(sgn_o), 0);
        chk("rst_pend", int'(pend_o), 0);
        chk("rst_force", int'(force_o), 0);
        chk("rst_sat", int'(sat_o), 0);
        model_reset();
        valid_i = 1'b0;
        @(posedge clk);
        #1;
        rstn_i = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rstn_i) begin
            if (valid_o) begin
                if (q.size() == 0) begin
                    chk("spurious_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("latency", cyc, e.cyc);
                    chk("out", int'($signed(out_o)), e.out);
                    chk("sgn", int'(sgn_o), e.sgn);
                    chk("pend", int'(pend_o), e.pend);
                    chk("force", int'(force_o), e.frc);
                    chk("sat", int'(sat_o), e.sat);
                    if (out_o == {1'b1, {(R-1){1'b0}}}) chk("never_min", 1, 0);
                end
            end else begin
                chk("force_idle", int'(force_o), 0);
            end
        end
    end

    initial begin
        int s, m;
        repeat (2) @(posedge clk);
        #1;
        rstn_i = 1'b1;
        // Reset during traffic, then first sample follows the IDLE rule.
        send(300, 1, 0, 0, 0);
        send(200, 0, 0, 5, 0);
        do_reset();
        send(100, 0, 0, 0, 0);
        // Deferred switch at a zero-crossing.
        send(FS, 1, 50, 10, 0);
        send(4000, 1, 50, 10, 0);
        send(1000, 1, 50, 10, 0);
        send(40, 1, 50, 10, 0);
        // Timeout-forced switch after three old-sign samples.
        send(0, 0, 0, 0, 0);
        repeat (4) send(500, 1, 0, 3, 0);
        // Cancelled request.
        send(0, 0, 0, 0, 0);
        send(500, 1, 0, 10, 0);
        send(500, 1, 0, 10, 0);
        send(500, 0, 0, 10, 0);
        send(500, 0, 0, 10, 0);
        // Bypass with a sign toggle every sample at full scale.
        for (int i = 0; i < 8; i++) send(FS, i % 2, 0, 10, 1);
        // Zero hold with gapped strobes.
        send(0, 0, 0, 0, 0);
        gap(2);
        send(8000, 1, 50, 0, 0);
        gap(3);
        send(8000, 1, 50, 0, 0);
        gap(1);
        // Randomized traffic, with one reset in the middle.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            m = $urandom_range(0, 9);
            m = m < 2 ? FS : m < 4 ? int'($urandom_range(0, 60)) : int'($urandom_range(0, FS));
            s = $urandom_range(0, 9) < 3 ? 1 - last_sgn : last_sgn;
            send(m, s, $urandom_range(0, 100), $urandom_range(0, 6),
                 $urandom_range(0, 9) == 0 ? 1 : 0);
            if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 2));
        end
        gap(5);
        chk("drain", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
